// File: rtl/cfg_write_sequencer_if.sv
// Request/config-bus bundle for cfg_write_sequencer.
// slave = sequencer view, master = requesters plus register-block observer.
interface cfg_write_sequencer_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [7:0]  req0_addr;
    logic [31:0] req0_data;
    logic [1:0]  req0_len;
    logic        req1_valid;
    logic        req1_ready;
    logic [7:0]  req1_addr;
    logic [31:0] req1_data;
    logic [1:0]  req1_len;
    logic        cfg_lock;
    logic        CFG_WE;
    logic [7:0]  CFG_ADDR;
    logic [7:0]  CFG_DATA;
    logic        busy;
    logic        done;
    logic        done_id;

    modport slave (
        input  req0_valid, req0_addr, req0_data, req0_len,
        input  req1_valid, req1_addr, req1_data, req1_len,
        input  cfg_lock,
        output req0_ready, req1_ready,
        output CFG_WE, CFG_ADDR, CFG_DATA, busy, done, done_id
    );

    modport master (
        output req0_valid, req0_addr, req0_data, req0_len,
        output req1_valid, req1_addr, req1_data, req1_len,
        output cfg_lock,
        input  req0_ready, req1_ready,
        input  CFG_WE, CFG_ADDR, CFG_DATA, busy, done, done_id
    );
endinterface

// File: rtl/cfg_write_sequencer.sv
// Round-robin arbiter that serialises 1-4 byte little-endian config words
// onto the 8-bit channel config bus as atomic bursts.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a grant; readies only here and only when unlocked
// S_WRITE | one-cycle byte strobe of byte r_idx at r_base + r_idx
// S_GAP   | CFG_WE low between bytes, r_gap counts down to 0
// S_DONE  | one-cycle done pulse carrying the requester id
module cfg_write_sequencer #(
    parameter int GAP_CYCLES = 1
) (
    input  logic                  CLK_LOW,
    input  logic                  reset_n,
    cfg_write_sequencer_if.slave  cfg_bus
);
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_base;
    logic [31:0] r_data;
    logic [1:0]  r_len, r_idx, w_idx_next;
    logic [3:0]  r_gap, w_gap_next;
    logic        r_id, r_last_grant;
    logic        w_grant_sel, w_ready0, w_ready1, w_accept;
    logic [7:0]  w_byte;

    // With both valid, the requester not served last wins.
    always_comb begin
        w_grant_sel = cfg_bus.req1_valid;
        if (cfg_bus.req0_valid && cfg_bus.req1_valid)
            w_grant_sel = ~r_last_grant;
        w_ready0 = (r_state == S_IDLE) && !cfg_bus.cfg_lock && !w_grant_sel;
        w_ready1 = (r_state == S_IDLE) && !cfg_bus.cfg_lock &&  w_grant_sel;
        w_accept = (w_ready0 && cfg_bus.req0_valid) || (w_ready1 && cfg_bus.req1_valid);
    end

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_gap_next = r_gap;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next     = S_WRITE;
                    w_idx_next = 2'd0;
                end
            end
            S_WRITE: begin
                if (r_idx == r_len) begin
                    w_next = S_DONE;
                end else if (GAP_CYCLES == 0) begin
                    w_idx_next = r_idx + 2'd1;
                end else begin
                    w_next     = S_GAP;
                    w_gap_next = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (r_gap == 4'd0) begin
                    w_next     = S_WRITE;
                    w_idx_next = r_idx + 2'd1;
                end else begin
                    w_gap_next = r_gap - 4'd1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_base       <= 8'd0;
            r_data       <= 32'd0;
            r_len        <= 2'd0;
            r_idx        <= 2'd0;
            r_gap        <= 4'd0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_gap   <= w_gap_next;
            if (w_accept) begin
                r_base       <= w_grant_sel ? cfg_bus.req1_addr : cfg_bus.req0_addr;
                r_data       <= w_grant_sel ? cfg_bus.req1_data : cfg_bus.req0_data;
                r_len        <= w_grant_sel ? cfg_bus.req1_len  : cfg_bus.req0_len;
                r_id         <= w_grant_sel;
                r_last_grant <= w_grant_sel;
            end
        end
    end

    always_comb begin
        case (r_idx)
            2'd0:    w_byte = r_data[7:0];
            2'd1:    w_byte = r_data[15:8];
            2'd2:    w_byte = r_data[23:16];
            default: w_byte = r_data[31:24];
        endcase
    end

    // Address/data are decoded from burst registers, so they hold through GAP.
    assign cfg_bus.req0_ready = w_ready0;
    assign cfg_bus.req1_ready = w_ready1;
    assign cfg_bus.CFG_WE     = (r_state == S_WRITE);
    assign cfg_bus.CFG_ADDR   = r_base + {6'd0, r_idx};
    assign cfg_bus.CFG_DATA   = w_byte;
    assign cfg_bus.busy       = (r_state != S_IDLE);
    assign cfg_bus.done       = (r_state == S_DONE);
    assign cfg_bus.done_id    = r_id;
endmodule
